nn_cmd_receiver: RTL and testbench

- Fabric-side consumer of the 32-bit CPU command word driven out of the chatbot SoC export PIO.
- Detects each new command using a sequence toggle bit and decodes the opcode.
- Buffers token IDs in a FIFO, streams them to the NN datapath with valid/ready, and captures the classification result.
- Drives a 32-bit status word back toward a SoC input PIO, so firmware can poll acknowledgements, state and result.

---
 rtl/nn_cmd_pkg.sv | 23 ++
 rtl/nn_tok_fifo.sv | 37 +++
 rtl/nn_cmd_receiver.sv | 93 +++++++++
 tb/tb_nn_cmd_receiver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nn_cmd_pkg.sv
// nn_cmd_pkg: opcodes, FSM states and field positions shared by the command receiver
package nn_cmd_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_ACK   = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADING = 3'd1,
    S_RUNNING = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;
  localparam int CMD_SEQ       = 31;
  localparam int CMD_OP_LSB    = 28;
  localparam int STS_ACK       = 31;
  localparam int STS_STATE_LSB = 28;
  localparam int STS_OVF       = 27;
  localparam int STS_ERR       = 26;
  localparam int STS_CNT_LSB   = 16;
  localparam int STS_RES_LSB   = 0;
endpackage

// File: rtl/nn_tok_fifo.sv
// nn_tok_fifo: show-ahead circular token buffer with synchronous flush
module nn_tok_fifo #(
  parameter int TOK_W = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [TOK_W-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [TOK_W-1:0]         dout
);
  localparam int AW = $clog2(DEPTH);
  logic [TOK_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/nn_cmd_receiver.sv
// nn_cmd_receiver: decodes SoC PIO command words, streams buffered tokens to the NN and reports status
module nn_cmd_receiver
  import nn_cmd_pkg::*;
#(
  parameter int TOK_W = 16,
  parameter int DEPTH = 64,
  parameter int CLS_W = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [31:0]      cmd_word,
  output logic [TOK_W-1:0] tok_data,
  output logic             tok_valid,
  output logic             tok_last,
  input  logic             tok_ready,
  output logic             nn_start,
  input  logic             nn_done,
  input  logic [CLS_W-1:0] nn_class,
  output logic [31:0]      status_word
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [31:0] cmd_q;
  logic last_seq, ovf_err, cmd_err, full, empty, cmd_det, legal, do_push, do_clear, pop;
  logic unused_rsvd;
  logic [2:0] op;
  logic [AW:0] count;
  logic [TOK_W-1:0] head;
  logic [CLS_W-1:0] result;
  state_t state, state_n;
  assign op = cmd_q[CMD_OP_LSB +: 3];
  assign cmd_det = cmd_q[CMD_SEQ] != last_seq;
  assign legal = op == OP_NOP || op == OP_CLEAR
              || (op == OP_PUSH && (state == S_IDLE || state == S_LOADING))
              || (op == OP_START && state == S_LOADING && count != '0)
              || (op == OP_ACK && state == S_DONE);
  assign do_push = cmd_det && legal && op == OP_PUSH;
  assign do_clear = cmd_det && op == OP_CLEAR;
  assign tok_valid = state == S_RUNNING && !empty;
  assign tok_last = tok_valid && count == ONE;
  assign tok_data = tok_valid ? head : '0;
  assign pop = tok_valid && tok_ready;
  assign unused_rsvd = ^cmd_q[27:16];
  nn_tok_fifo #(.TOK_W(TOK_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst_n(reset_reset_n),
    .push(do_push),
    .pop(pop),
    .flush(do_clear),
    .din(cmd_q[TOK_W-1:0]),
    .full(full),
    .empty(empty),
    .count(count),
    .dout(head)
  );
  // a legal command overrides the stream/result transitions of the same cycle
  always_comb begin
    state_n = state;
    if (state == S_RUNNING && pop && count == ONE) state_n = S_WAIT;
    if (state == S_WAIT && nn_done) state_n = S_DONE;
    if (cmd_det && legal)
      state_n = (op == OP_CLEAR || op == OP_ACK) ? S_IDLE :
                op == OP_PUSH ? S_LOADING :
                op == OP_START ? S_RUNNING : state_n;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      cmd_q    <= '0;
      last_seq <= 1'b0;
      state    <= S_IDLE;
      nn_start <= 1'b0;
      ovf_err  <= 1'b0;
      cmd_err  <= 1'b0;
      result   <= '0;
    end else begin
      cmd_q    <= cmd_word;
      last_seq <= cmd_q[CMD_SEQ];
      state    <= state_n;
      nn_start <= cmd_det && legal && op == OP_START;
      ovf_err  <= !do_clear && (ovf_err || (do_push && full));
      cmd_err  <= !do_clear && (cmd_err || (cmd_det && !legal));
      result   <= do_clear ? '0 : (state == S_WAIT && nn_done) ? nn_class : result;
    end
  always_comb begin
    status_word = '0;
    status_word[STS_ACK] = last_seq;
    status_word[STS_STATE_LSB +: 3] = state;
    status_word[STS_OVF] = ovf_err;
    status_word[STS_ERR] = cmd_err;
    status_word[STS_CNT_LSB +: 10] = 10'(count);
    status_word[STS_RES_LSB +: 16] = 16'(result);
  end
endmodule

// File: tb/tb_nn_cmd_receiver.sv
// tb_nn_cmd_receiver: randomized scoreboard bench against a queue-based command model
module tb_nn_cmd_receiver;
  localparam int DEPTH = 64;
  logic clk_clk = 0, reset_reset_n = 0, tok_ready = 0, nn_done = 0;
  logic [31:0] cmd_word = '0;
  logic [15:0] nn_class = '0;
  logic [15:0] tok_data;
  logic tok_valid, tok_last, nn_start;
  logic [31:0] status_word;
  int tests = 0, fails = 0, n_start = 0, exp_start = 0;
  logic seq = 0, ovf = 0, err = 0;
  logic [15:0] res = '0;
  int st = 0;
  logic [15:0] mq[$];
  logic [15:0] exp_tok[$];
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk_clk = ~clk_clk;

  nn_cmd_receiver #(.TOK_W(16), .DEPTH(DEPTH), .CLS_W(16)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .cmd_word(cmd_word),
    .tok_data(tok_data),
    .tok_valid(tok_valid),
    .tok_last(tok_last),
    .tok_ready(tok_ready),
    .nn_start(nn_start),
    .nn_done(nn_done),
    .nn_class(nn_class),
    .status_word(status_word)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int cnt = (st == 2) ? exp_tok.size() : mq.size();
    return {seq, 3'(st), ovf, err, 10'(cnt), res};
  endfunction

  task automatic model(int op, logic [15:0] d);
    case (op)
      0: ;
      1: begin mq.delete(); exp_tok.delete(); ovf = 0; err = 0; res = '0; st = 0; end
      2: if (st <= 1) begin
           if (mq.size() < DEPTH) mq.push_back(d); else ovf = 1;
           st = 1;
         end else err = 1;
      3: if (st == 1 && mq.size() > 0) begin
           exp_tok = mq; mq.delete(); st = 2; exp_start++;
         end else err = 1;
      4: if (st == 4) st = 0; else err = 1;
      default: err = 1;
    endcase
  endtask

  task automatic cmd(int op, logic [15:0] d);
    @(posedge clk_clk); #1;
    tok_ready = 0;
    seq = ~seq;
    cmd_word = {seq, 3'(op), 12'h000, d};
    repeat (2) @(negedge clk_clk);
    check("ack_hold", status_word[31], !seq);
    @(posedge clk_clk); #1;
    model(op, d);
    @(negedge clk_clk);
    check($sformatf("status_op%0d", op), status_word, exp_status());
  endtask

  task automatic drain(int mode);
    int n = 0;
    while (exp_tok.size() != 0 && n < 1000) begin
      @(posedge clk_clk); #1;
      tok_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 4] : 1'($urandom_range(0, 1));
      n++;
    end
    tok_ready = 0;
    check("drain", exp_tok.size(), 0);
    st = 3;
    @(negedge clk_clk);
    check("status_wait", status_word, exp_status());
  endtask

  task automatic done(logic [15:0] c);
    @(posedge clk_clk); #1;
    nn_done = 1;
    nn_class = c;
    @(posedge clk_clk); #1;
    nn_done = 0;
    if (st == 3) begin res = c; st = 4; end
    @(negedge clk_clk);
    check("status_done", status_word, exp_status());
  endtask

  // monitor: every valid token must match the scoreboard head; handshakes pop it
  always @(negedge clk_clk) if (reset_reset_n) begin
    if (nn_start) n_start++;
    if (tok_valid) begin
      if (exp_tok.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tok_unexpected: got %h, want no token", tok_data);
      end else begin
        check("tok_data", tok_data, exp_tok[0]);
        if (tok_ready) begin
          check("tok_last", tok_last, exp_tok.size() == 1);
          void'(exp_tok.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_clk);
    check("rst_status", status_word, 32'h0);
    check("rst_valid", tok_valid, 1'b0);
    check("rst_start", nn_start, 1'b0);
    @(negedge clk_clk);
    reset_reset_n = 1;
    cmd(2, 16'h0011);
    cmd(2, 16'h0022);
    cmd(2, 16'h0033);
    cmd(3, 16'h0000);
    drain(0);
    done(16'h0005);
    cmd(4, 16'h0000);
    for (int i = 0; i < 5; i++) cmd(2, 16'($urandom));
    cmd(3, 16'h0000);
    drain(1);
    done(16'($urandom));
    cmd(4, 16'h0000);
    for (int i = 0; i < DEPTH + 1; i++) cmd(2, 16'($urandom));
    cmd(1, 16'h0000);
    cmd(3, 16'h0000);
    cmd(6, 16'h0000);
    @(posedge clk_clk); #1;
    cmd_word = {seq, 3'd2, 12'h000, 16'hBEEF};
    repeat (3) @(negedge clk_clk);
    check("same_seq", status_word, exp_status());
    cmd(2, 16'h00A1);
    cmd(2, 16'h00A2);
    cmd(3, 16'h0000);
    cmd(1, 16'h0000);
    done(16'h0077);
    cmd(2, 16'h00B1);
    cmd(3, 16'h0000);
    drain(2);
    cmd(1, 16'h0000);
    done(16'h0099);
    for (int i = 0; i < 80; i++) begin
      cmd($urandom_range(0, 7), 16'($urandom));
      if (st == 2) drain(2);
      if ($urandom_range(0, 2) == 0) done(16'($urandom));
    end
    cmd(1, 16'h0000);
    cmd(2, 16'h0C01);
    cmd(2, 16'h0C02);
    cmd(3, 16'h0000);
    check("pre_rst_valid", tok_valid, 1'b1);
    @(posedge clk_clk); #2;
    reset_reset_n = 0;
    cmd_word = '0;
    #1;
    check("async_rst_valid", tok_valid, 1'b0);
    check("async_rst_status", status_word, 32'h0);
    mq.delete();
    exp_tok.delete();
    st = 0; ovf = 0; err = 0; res = '0; seq = 0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1;
    cmd(2, 16'h1234);
    check("nn_start_count", n_start, exp_start);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
